// File: rtl/tinyml_load_pkg.sv
// Shared types and constants for the LOAD path: FSM states, tile type and the
// per-beat length mask applied while packing elements into a tile.
package tinyml_load_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int TILE_WIDTH     = 256;
  localparam int TILE_ELEMS     = TILE_WIDTH / DATA_WIDTH;
  localparam int MEM_DATA_WIDTH = 64;
  localparam int BEAT_ELEMS     = MEM_DATA_WIDTH / DATA_WIDTH;
  localparam int BEATS_PER_TILE = TILE_WIDTH / MEM_DATA_WIDTH;
  localparam int ADDR_WIDTH     = 24;
  localparam int LEN_WIDTH      = 20;

  localparam logic [LEN_WIDTH:0]    BEAT_STEP       = (LEN_WIDTH + 1)'(BEAT_ELEMS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP       = ADDR_WIDTH'(MEM_DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = ~(ADDR_WIDTH'(MEM_DATA_WIDTH / 8 - 1));
  localparam logic [1:0]            LAST_SLOT       = 2'(BEATS_PER_TILE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } load_state_t;

  typedef logic [TILE_WIDTH-1:0] tile_t;

  // Zero every element of a beat whose absolute index lies at or past the length.
  function automatic logic [MEM_DATA_WIDTH-1:0] mask_beat(
    input logic [MEM_DATA_WIDTH-1:0] beat,
    input logic [LEN_WIDTH:0]        base,
    input logic [LEN_WIDTH-1:0]      len
  );
    logic [MEM_DATA_WIDTH-1:0] res;
    logic [LEN_WIDTH+1:0]      elem;
    res = beat;
    for (int j = 0; j < BEAT_ELEMS; j++) begin
      elem = {1'b0, base} + (LEN_WIDTH + 2)'(j);
      res[j*DATA_WIDTH +: DATA_WIDTH] = (elem >= {2'b00, len}) ? 8'h00
                                        : beat[j*DATA_WIDTH +: DATA_WIDTH];
    end
    return res;
  endfunction

endpackage

// File: rtl/tile_assembler.sv
// Holds the tile under construction: drops each masked beat into its slot and
// clears the whole tile when a command starts or a tile has been written.
module tile_assembler
  import tinyml_load_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      load,
  input  logic [1:0]                slot,
  input  logic [LEN_WIDTH:0]        elem_base,
  input  logic [LEN_WIDTH-1:0]      length,
  input  logic [MEM_DATA_WIDTH-1:0] beat,
  output tile_t                     tile_r
);

  tile_t tile_next_s;

  // Next tile value: clear wins over a beat load.
  always_comb begin
    tile_next_s = tile_r;
    if (clear) begin
      tile_next_s = '0;
    end else if (load) begin
      tile_next_s[{slot, 6'd0} +: MEM_DATA_WIDTH] = mask_beat(beat, elem_base, length);
    end else begin
      tile_next_s = tile_r;
    end
  end

  // Tile storage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_r <= '0;
    end else begin
      tile_r <= tile_next_s;
    end
  end

endmodule

// File: rtl/tile_load_sequencer.sv
// Executes one LOAD command: fetches int8 elements as 64-bit beats, packs them
// into 256-bit tiles and pulses one buffer write per tile, then signals done.
module tile_load_sequencer
  import tinyml_load_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_matrix,
  input  logic [ADDR_WIDTH-1:0]     dram_addr,
  input  logic [LEN_WIDTH-1:0]      length,
  input  logic [4:0]                buffer_id,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic                      mem_rvalid,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  output logic                      vec_write_enable,
  output logic                      mat_write_enable,
  output logic [4:0]                write_buffer_id,
  output logic [TILE_WIDTH-1:0]     write_tile,
  output logic [LEN_WIDTH-1:0]      tiles_written
);

  load_state_t           state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [4:0]            buf_id_r;
  logic                  is_mat_r;
  logic [1:0]            beat_idx_r;
  logic [LEN_WIDTH:0]    elem_cnt_r;

  logic [LEN_WIDTH:0]    elem_sum_s;
  logic [LEN_WIDTH:0]    elem_next_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic [ADDR_WIDTH-1:0] aligned_addr_s;
  logic                  asm_clear_s;
  logic                  asm_load_s;
  tile_t                 tile_s;

  // Saturating element count, next beat address and assembler controls.
  always_comb begin
    elem_sum_s = elem_cnt_r + BEAT_STEP;
    if (elem_sum_s >= {1'b0, len_r}) begin
      elem_next_s = {1'b0, len_r};
    end else begin
      elem_next_s = elem_sum_s;
    end
    addr_next_s    = addr_r + ADDR_STEP;
    aligned_addr_s = dram_addr & ADDR_ALIGN_MASK;
    asm_clear_s    = ((state_r == ST_IDLE) && start) || (state_r == ST_WRITE);
    asm_load_s     = (state_r == ST_WAIT) && mem_rvalid;
  end

  tile_assembler u_tile_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear_s),
    .load      (asm_load_s),
    .slot      (beat_idx_r),
    .elem_base (elem_cnt_r),
    .length    (len_r),
    .beat      (mem_rdata),
    .tile_r    (tile_s)
  );

  assign write_tile = tile_s;

  // Command FSM; every output is set on the transition into the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      addr_r           <= '0;
      len_r            <= '0;
      buf_id_r         <= 5'd0;
      is_mat_r         <= 1'b0;
      beat_idx_r       <= 2'd0;
      elem_cnt_r       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_req_valid    <= 1'b0;
      mem_addr         <= '0;
      vec_write_enable <= 1'b0;
      mat_write_enable <= 1'b0;
      write_buffer_id  <= 5'd0;
      tiles_written    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr_r        <= aligned_addr_s;
            len_r         <= length;
            buf_id_r      <= buffer_id;
            is_mat_r      <= is_matrix;
            beat_idx_r    <= 2'd0;
            elem_cnt_r    <= '0;
            tiles_written <= '0;
            busy          <= 1'b1;
            if (length == '0) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_r       <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= aligned_addr_s;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_r       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            elem_cnt_r <= elem_next_s;
            addr_r     <= addr_next_s;
            if ((beat_idx_r == LAST_SLOT) || (elem_next_s == {1'b0, len_r})) begin
              state_r          <= ST_WRITE;
              vec_write_enable <= ~is_mat_r;
              mat_write_enable <= is_mat_r;
              write_buffer_id  <= buf_id_r;
            end else begin
              beat_idx_r    <= beat_idx_r + 2'd1;
              state_r       <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= addr_next_s;
            end
          end
        end
        ST_WRITE: begin
          vec_write_enable <= 1'b0;
          mat_write_enable <= 1'b0;
          tiles_written    <= tiles_written + LEN_WIDTH'(1);
          beat_idx_r       <= 2'd0;
          if (elem_cnt_r < {1'b0, len_r}) begin
            state_r       <= ST_REQ;
            mem_req_valid <= 1'b1;
            mem_addr      <= addr_r;
          end else begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r          <= ST_IDLE;
          busy             <= 1'b0;
          done             <= 1'b0;
          mem_req_valid    <= 1'b0;
          vec_write_enable <= 1'b0;
          mat_write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
